// File: rtl/fitness_pkg.sv
// rtl/fitness_pkg.sv - shared defaults and helpers for the 2-D fitness evaluator
package fitness_pkg;

    localparam int DEF_NUM_PARTICLE_TYPE = 3;
    localparam int DEF_DATA_WIDTH        = 4;
    localparam int DEF_PARTICLE_LENGTH   = 2;
    localparam int DEF_ROWS              = 4;
    localparam int DEF_COLS              = 4;
    localparam int DEF_SELF_FIT_LENGTH   = 12;
    localparam int DEF_POP_SIZE          = 50;
    localparam int DEF_IDX_W             = $clog2(DEF_POP_SIZE);

    // Internal sum width: every site self term plus at most two pairs per site,
    // each pair counted twice, all at the largest table entry, plus one guard bit.
    function automatic int energy_width(input int rows, input int cols, input int dw);
        int max_sum;
        max_sum = ((1 << dw) - 1) * (5 * rows * cols);
        return $clog2(max_sum + 1) + 1;
    endfunction

    // LSB of field idx in a packed table whose field 0 sits in the most significant slot.
    function automatic int field_lsb(input int idx, input int nfields, input int w);
        return (nfields - 1 - idx) * w;
    endfunction

    // LSB of lattice site (r,c) inside the packed individual.
    function automatic int site_lsb(input int r, input int c, input int cols, input int pl);
        return (r * cols + c) * pl;
    endfunction

endpackage

// File: rtl/fitness_eval_2d_if.sv
// rtl/fitness_eval_2d_if.sv - individual in / energy out stream bundle
interface fitness_eval_2d_if
    import fitness_pkg::*;
#(
    parameter int ROWS            = DEF_ROWS,
    parameter int COLS            = DEF_COLS,
    parameter int PARTICLE_LENGTH = DEF_PARTICLE_LENGTH,
    parameter int SELF_FIT_LENGTH = DEF_SELF_FIT_LENGTH,
    parameter int IDX_W           = DEF_IDX_W
) ();

    logic                                  in_valid_i;
    logic                                  in_ready_o;
    logic [ROWS*COLS*PARTICLE_LENGTH-1:0]  individual_vec_i;
    logic [IDX_W-1:0]                      ind_idx_i;
    logic                                  out_valid_o;
    logic                                  out_ready_i;
    logic [SELF_FIT_LENGTH-1:0]            total_energy_o;
    logic                                  sat_o;
    logic                                  bad_code_o;
    logic [IDX_W-1:0]                      ind_wb_idx_o;
    logic                                  done_o;

    // Evaluator side
    modport slave (
        input  in_valid_i, individual_vec_i, ind_idx_i, out_ready_i,
        output in_ready_o, out_valid_o, total_energy_o, sat_o, bad_code_o,
               ind_wb_idx_o, done_o
    );

    // Population memory / selection side
    modport master (
        output in_valid_i, individual_vec_i, ind_idx_i, out_ready_i,
        input  in_ready_o, out_valid_o, total_energy_o, sat_o, bad_code_o,
               ind_wb_idx_o, done_o
    );

endinterface

// File: rtl/fitness_pair_lut.sv
// rtl/fitness_pair_lut.sv - interaction term lookup for one site pair
module fitness_pair_lut
    import fitness_pkg::*;
#(
    parameter int NUM_PARTICLE_TYPE = DEF_NUM_PARTICLE_TYPE,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int PARTICLE_LENGTH   = DEF_PARTICLE_LENGTH
) (
    input  logic [PARTICLE_LENGTH-1:0]                                i_code_a,
    input  logic [PARTICLE_LENGTH-1:0]                                i_code_b,
    input  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] i_interact,
    output logic [DATA_WIDTH-1:0]                                     o_term
);

    localparam int NPT = NUM_PARTICLE_TYPE;

    logic w_a_ok;
    logic w_b_ok;

    assign w_a_ok = int'(i_code_a) < NPT;
    assign w_b_ok = int'(i_code_b) < NPT;

    // A pair touching an undefined species contributes nothing
    always_comb begin
        o_term = '0;
        if (w_a_ok && w_b_ok) begin
            o_term = i_interact[field_lsb(int'(i_code_a) * NPT + int'(i_code_b),
                                          NPT * NPT, DATA_WIDTH) +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/fitness_eval_2d.sv
// rtl/fitness_eval_2d.sv - pipelined 2-D lattice energy evaluator, one individual per cycle
module fitness_eval_2d
    import fitness_pkg::*;
#(
    parameter int NUM_PARTICLE_TYPE = DEF_NUM_PARTICLE_TYPE,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int PARTICLE_LENGTH   = DEF_PARTICLE_LENGTH,
    parameter int ROWS              = DEF_ROWS,
    parameter int COLS              = DEF_COLS,
    parameter int SELF_FIT_LENGTH   = DEF_SELF_FIT_LENGTH,
    parameter int POP_SIZE          = DEF_POP_SIZE,
    parameter int IDX_W             = $clog2(POP_SIZE)
) (
    input  logic                                                      clk_i,
    input  logic                                                      rst_i,
    input  logic                                                      cfg_load_i,
    input  logic                                                      periodic_i,
    input  logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]                   self_energy_vec_i,
    input  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] interact_matrix_i,
    fitness_eval_2d_if.slave                                          bus
);

    localparam int NPT = NUM_PARTICLE_TYPE;
    localparam int DW  = DATA_WIDTH;
    localparam int PL  = PARTICLE_LENGTH;
    localparam int SFL = SELF_FIT_LENGTH;
    localparam int NS  = ROWS * COLS;
    localparam int EW  = energy_width(ROWS, COLS, DW);
    localparam int TW  = (EW > SFL) ? EW : SFL + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POP_SIZE - 1);

    // Latched configuration
    logic [NPT*DW-1:0]     r_self_tbl;
    logic [NPT*NPT*DW-1:0] r_pair_tbl;
    logic                  r_periodic;

    // Input capture
    logic                  r_v0;
    logic [NS*PL-1:0]      r_ind0;
    logic [IDX_W-1:0]      r_idx0;

    // S1: looked-up terms
    logic                  r_v1;
    logic                  r_bad1;
    logic [IDX_W-1:0]      r_idx1;
    logic [DW-1:0]         r_self1  [NS];
    logic [DW-1:0]         r_right1 [NS];
    logic [DW-1:0]         r_down1  [NS];

    // S2: row sums
    logic                  r_v2;
    logic                  r_bad2;
    logic [IDX_W-1:0]      r_idx2;
    logic [EW-1:0]         r_row2   [ROWS];

    // S3: output register
    logic                  r_v3;
    logic                  r_sat3;
    logic                  r_bad3;
    logic [IDX_W-1:0]      r_idx3;
    logic [SFL-1:0]        r_energy3;

    logic [IDX_W-1:0]      r_cnt;

    logic                  w_stall;
    logic                  w_accept;
    logic                  w_empty;
    logic                  w_out_hs;
    logic [PL-1:0]         w_code   [NS];
    logic [DW-1:0]         w_self   [NS];
    logic [DW-1:0]         w_right  [NS];
    logic [DW-1:0]         w_down   [NS];
    logic [NS-1:0]         w_site_bad;
    logic [EW-1:0]         w_row    [ROWS];
    logic [TW-1:0]         w_total;
    logic                  w_sat;
    logic [SFL-1:0]        w_energy;

    assign w_stall        = r_v3 && !bus.out_ready_i;
    assign bus.in_ready_o = !rst_i && !w_stall && !cfg_load_i;
    assign w_accept       = bus.in_valid_i && bus.in_ready_o;
    assign w_empty        = !(r_v0 || r_v1 || r_v2 || r_v3);
    assign w_out_hs       = r_v3 && bus.out_ready_i;

    // Each site owns its right and down pair; wrap pairs only exist in periodic
    // mode and only along dimensions of 3 or more, so no pair is counted twice.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            localparam int S  = gr * COLS + gc;
            localparam int RN = gr * COLS + ((gc + 1) % COLS);
            localparam int DN = ((gr + 1) % ROWS) * COLS + gc;
            localparam bit H_EDGE = (gc == COLS - 1);
            localparam bit V_EDGE = (gr == ROWS - 1);
            localparam bit H_WRAP = (COLS >= 3);
            localparam bit V_WRAP = (ROWS >= 3);

            logic [DW-1:0] w_right_raw;
            logic [DW-1:0] w_down_raw;
            logic          w_right_en;
            logic          w_down_en;

            assign w_code[S]     = r_ind0[site_lsb(gr, gc, COLS, PL) +: PL];
            assign w_site_bad[S] = int'(w_code[S]) >= NPT;
            assign w_self[S]     = w_site_bad[S] ? '0 :
                                   r_self_tbl[field_lsb(int'(w_code[S]), NPT, DW) +: DW];
            assign w_right_en    = !H_EDGE || (r_periodic && H_WRAP);
            assign w_down_en     = !V_EDGE || (r_periodic && V_WRAP);
            assign w_right[S]    = w_right_en ? w_right_raw : '0;
            assign w_down[S]     = w_down_en  ? w_down_raw  : '0;

            fitness_pair_lut #(
                .NUM_PARTICLE_TYPE (NPT),
                .DATA_WIDTH        (DW),
                .PARTICLE_LENGTH   (PL)
            ) u_right (
                .i_code_a   (w_code[S]),
                .i_code_b   (w_code[RN]),
                .i_interact (r_pair_tbl),
                .o_term     (w_right_raw)
            );

            fitness_pair_lut #(
                .NUM_PARTICLE_TYPE (NPT),
                .DATA_WIDTH        (DW),
                .PARTICLE_LENGTH   (PL)
            ) u_down (
                .i_code_a   (w_code[S]),
                .i_code_b   (w_code[DN]),
                .i_interact (r_pair_tbl),
                .o_term     (w_down_raw)
            );
        end
    end

    // Row partial sums: self terms plus both owned pairs doubled
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            w_row[r] = '0;
            for (int c = 0; c < COLS; c++) begin
                w_row[r] = w_row[r] + EW'(r_self1[r*COLS+c])
                                    + (EW'(r_right1[r*COLS+c]) << 1)
                                    + (EW'(r_down1[r*COLS+c]) << 1);
            end
        end
    end

    // Final sum of rows, then clip to the output width
    always_comb begin
        w_total = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_total = w_total + TW'(r_row2[r]);
        end
    end

    assign w_sat    = |w_total[TW-1:SFL];
    assign w_energy = w_sat ? '1 : w_total[SFL-1:0];

    // Tables change only with nothing in flight, so no individual sees two versions
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_self_tbl <= '0;
            r_pair_tbl <= '0;
            r_periodic <= 1'b0;
        end else if (cfg_load_i && w_empty) begin
            r_self_tbl <= self_energy_vec_i;
            r_pair_tbl <= interact_matrix_i;
            r_periodic <= periodic_i;
        end
    end

    // Input capture stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v0   <= 1'b0;
            r_ind0 <= '0;
            r_idx0 <= '0;
        end else if (!w_stall) begin
            r_v0 <= w_accept;
            if (w_accept) begin
                r_ind0 <= bus.individual_vec_i;
                r_idx0 <= bus.ind_idx_i;
            end
        end
    end

    // S1: register per-site self and pair terms
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v1   <= 1'b0;
            r_bad1 <= 1'b0;
            r_idx1 <= '0;
            for (int s = 0; s < NS; s++) begin
                r_self1[s]  <= '0;
                r_right1[s] <= '0;
                r_down1[s]  <= '0;
            end
        end else if (!w_stall) begin
            r_v1     <= r_v0;
            r_bad1   <= |w_site_bad;
            r_idx1   <= r_idx0;
            r_self1  <= w_self;
            r_right1 <= w_right;
            r_down1  <= w_down;
        end
    end

    // S2: register row sums
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v2   <= 1'b0;
            r_bad2 <= 1'b0;
            r_idx2 <= '0;
            for (int r = 0; r < ROWS; r++) begin
                r_row2[r] <= '0;
            end
        end else if (!w_stall) begin
            r_v2   <= r_v1;
            r_bad2 <= r_bad1;
            r_idx2 <= r_idx1;
            r_row2 <= w_row;
        end
    end

    // S3: saturated total held until the consumer takes it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v3      <= 1'b0;
            r_sat3    <= 1'b0;
            r_bad3    <= 1'b0;
            r_idx3    <= '0;
            r_energy3 <= '0;
        end else if (!w_stall) begin
            r_v3      <= r_v2;
            r_sat3    <= w_sat;
            r_bad3    <= r_bad2;
            r_idx3    <= r_idx2;
            r_energy3 <= w_energy;
        end
    end

    // Population counter advances on each handed-off result and wraps after the last
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_out_hs) begin
            r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + IDX_W'(1);
        end
    end

    assign bus.out_valid_o    = r_v3;
    assign bus.total_energy_o = r_energy3;
    assign bus.sat_o          = r_sat3;
    assign bus.bad_code_o     = r_bad3;
    assign bus.ind_wb_idx_o   = r_idx3;
    assign bus.done_o         = r_v3 && (r_cnt == LAST_IDX);

endmodule

// File: tb/tb_fitness_eval_2d.sv
// tb/tb_fitness_eval_2d.sv - directed-vector bench for fitness_eval_2d
module tb_fitness_eval_2d;

    localparam logic [11:0] DEF_SELF = 12'h123;        // {1,2,3}
    localparam logic [35:0] DEF_INT  = 36'hA414A515A;  // [[10,4,1],[4,10,5],[1,5,10]]
    localparam logic [11:0] SAT_SELF = 12'h12F;        // {1,2,15}
    localparam logic [35:0] SAT_INT  = 36'hA414A515F;  // [2][2]=15
    localparam logic [31:0] ALL0 = 32'h00000000;
    localparam logic [31:0] CHK  = 32'h11441144;       // (r+c) odd -> type 1
    localparam logic [31:0] ALL2 = 32'hAAAAAAAA;
    localparam logic [31:0] BAD0 = 32'h00000003;       // site (0,0) = code 3

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic        periodic;
    logic [11:0] self_vec;
    logic [35:0] inter;

    int n_vec = 0;
    int n_err = 0;

    fitness_eval_2d_if #(
        .ROWS(4), .COLS(4), .PARTICLE_LENGTH(2), .SELF_FIT_LENGTH(10), .IDX_W(6)
    ) bus ();

    fitness_eval_2d #(
        .SELF_FIT_LENGTH (10)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .cfg_load_i        (cfg_load),
        .periodic_i        (periodic),
        .self_energy_vec_i (self_vec),
        .interact_matrix_i (inter),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_cfg(input logic [11:0] s, input logic [35:0] m, input logic p);
        @(negedge clk);
        self_vec = s; inter = m; periodic = p; cfg_load = 1'b1;
        #1 check("cfg_in_ready", 32'(bus.in_ready_o), 0);
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [31:0] ind, input int exp_e,
                           input bit exp_sat, input bit exp_bad);
        int k;
        @(negedge clk);
        bus.individual_vec_i = ind;
        bus.ind_idx_i        = 6'd17;
        bus.in_valid_i       = 1'b1;
        #1 check({tag, "_in_ready"}, 32'(bus.in_ready_o), 1);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        k = 1;
        while (!bus.out_valid_o && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 32'(k - 1), 3);
        check({tag, "_energy"},  32'(bus.total_energy_o), 32'(exp_e));
        check({tag, "_sat"},     32'(bus.sat_o), 32'(exp_sat));
        check({tag, "_bad"},     32'(bus.bad_code_o), 32'(exp_bad));
        check({tag, "_idx"},     32'(bus.ind_wb_idx_o), 17);
        @(negedge clk);
        check({tag, "_drained"}, 32'(bus.out_valid_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] pat_v [4];
        int          pat_e [4];
        int          k;
        pat_v = '{ALL0, CHK, ALL2, BAD0};
        pat_e = '{496, 216, 528, 455};

        rst = 1'b1; cfg_load = 1'b0; periodic = 1'b0; self_vec = '0; inter = '0;
        bus.in_valid_i = 1'b0; bus.individual_vec_i = '0; bus.ind_idx_i = '0;
        bus.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid_o), 0);
        check("rst_energy",    32'(bus.total_energy_o), 0);
        check("rst_sat",       32'(bus.sat_o), 0);
        check("rst_bad",       32'(bus.bad_code_o), 0);
        check("rst_idx",       32'(bus.ind_wb_idx_o), 0);
        check("rst_done",      32'(bus.done_o), 0);
        check("rst_in_ready",  32'(bus.in_ready_o), 0);
        rst = 1'b0;

        load_cfg(DEF_SELF, DEF_INT, 1'b0);
        run_one("open_all0", ALL0, 496, 0, 0);
        run_one("open_chk",  CHK,  216, 0, 0);
        run_one("open_all2", ALL2, 528, 0, 0);
        run_one("open_bad",  BAD0, 455, 0, 1);

        load_cfg(DEF_SELF, DEF_INT, 1'b1);
        run_one("per_all0", ALL0, 656, 0, 0);
        run_one("per_chk",  CHK,  280, 0, 0);
        run_one("per_bad",  BAD0, 575, 0, 1);

        load_cfg(SAT_SELF, SAT_INT, 1'b1);
        run_one("sat_per",  ALL2, 1023, 1, 0);
        load_cfg(SAT_SELF, SAT_INT, 1'b0);
        run_one("sat_open", ALL2, 960, 0, 0);

        // configuration pulse while an individual is in flight must be ignored
        load_cfg(DEF_SELF, DEF_INT, 1'b0);
        @(negedge clk);
        bus.individual_vec_i = ALL0; bus.ind_idx_i = 6'd3; bus.in_valid_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        self_vec = SAT_SELF; inter = SAT_INT; periodic = 1'b1; cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        k = 0;
        while (!bus.out_valid_o && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("busy_cfg_energy", 32'(bus.total_energy_o), 496);
        run_one("busy_cfg_after", ALL2, 528, 0, 0);

        // reset with results in flight
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.individual_vec_i = ALL0; bus.ind_idx_i = 6'(i); bus.in_valid_i = 1'b1;
        end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        check("midrst_pre_valid", 32'(bus.out_valid_o), 1);
        rst = 1'b1;
        #1;
        check("midrst_valid",  32'(bus.out_valid_o), 0);
        check("midrst_done",   32'(bus.done_o), 0);
        check("midrst_energy", 32'(bus.total_energy_o), 0);
        @(negedge clk);
        rst = 1'b0;
        load_cfg(DEF_SELF, DEF_INT, 1'b0);

        // 51-result stream with a 5-cycle stall and random stalls
        fork
            begin : producer
                int sent;
                int guard;
                bit acc;
                sent = 0; guard = 0;
                while (sent < 51 && guard < 3000) begin
                    @(negedge clk);
                    bus.in_valid_i       = 1'b1;
                    bus.individual_vec_i = pat_v[sent % 4];
                    bus.ind_idx_i        = 6'(sent % 50);
                    #2 acc = bus.in_ready_o;
                    @(posedge clk);
                    if (acc) sent++;
                    guard++;
                end
                @(negedge clk);
                bus.in_valid_i = 1'b0;
            end
            begin : consumer
                int got;
                int cyc;
                bit prev_stall;
                logic [9:0] prev_e;
                logic [5:0] prev_idx;
                got = 0; cyc = 0; prev_stall = 1'b0; prev_e = '0; prev_idx = '0;
                while (got < 51 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (cyc >= 20 && cyc < 25) bus.out_ready_i = 1'b0;
                    else bus.out_ready_i = ($urandom_range(0, 3) != 0);
                    #1;
                    if (prev_stall && bus.out_valid_o) begin
                        check("stall_hold_energy", 32'(bus.total_energy_o), 32'(prev_e));
                        check("stall_hold_idx",    32'(bus.ind_wb_idx_o), 32'(prev_idx));
                    end
                    prev_stall = bus.out_valid_o && !bus.out_ready_i;
                    prev_e     = bus.total_energy_o;
                    prev_idx   = bus.ind_wb_idx_o;
                    if (bus.out_valid_o && !bus.out_ready_i)
                        check("stall_in_ready", 32'(bus.in_ready_o), 0);
                    if (bus.out_valid_o && bus.out_ready_i) begin
                        check("stream_idx",    32'(bus.ind_wb_idx_o), 32'(got % 50));
                        check("stream_energy", 32'(bus.total_energy_o), 32'(pat_e[got % 4]));
                        check("stream_bad",    32'(bus.bad_code_o), 32'((got % 4) == 3));
                        check("stream_done",   32'(bus.done_o), 32'(got == 49));
                        got++;
                    end
                end
                check("stream_count", 32'(got), 51);
                bus.out_ready_i = 1'b1;
            end
        join

        repeat (6) @(negedge clk);
        check("stream_tail_empty", 32'(bus.out_valid_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fitness_eval_2d.md
# fitness_eval_2d

Pipelined lattice-energy evaluator for the GA population loop: it scores one ROWS×COLS individual per cycle. It generalises the 1-D fitness evaluator in three ways: a 2-D lattice, an optional periodic (toroidal) boundary, and valid/ready backpressure with saturating results. It sits between the population memory and the selection stage, and returns each energy with its individual index for write-back.

## Interface
- NUM_PARTICLE_TYPE, 3, number of particle species
- DATA_WIDTH, 4, width of each self or interaction energy entry
- PARTICLE_LENGTH, 2, bits per lattice site
- ROWS, 4, lattice rows
- COLS, 4, lattice columns
- SELF_FIT_LENGTH, 12, width of the total energy
- POP_SIZE, 50, individuals per generation
- IDX_W, $clog2(POP_SIZE), index width
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- cfg_load_i  in  1  latch energy tables this cycle
- periodic_i  in  1  boundary mode, latched with the tables: 0 open, 1 periodic
- self_energy_vec_i  in  NUM_PARTICLE_TYPE*DATA_WIDTH  type 0 in the most significant field
- interact_matrix_i  in  NUM_PARTICLE_TYPE²*DATA_WIDTH  row-major; [0][0] in the most significant field
- in_valid_i  in  1  individual present
- in_ready_o  out  1  individual accepted when in_valid_i && in_ready_o
- individual_vec_i  in  ROWS*COLS*PARTICLE_LENGTH  site (r,c) at [PL*(r*COLS+c) +: PL]
- ind_idx_i  in  IDX_W  individual index
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts the result
- total_energy_o  out  SELF_FIT_LENGTH  energy, saturated
- sat_o  out  1  saturation occurred for this result
- bad_code_o  out  1  some site code was ≥ NUM_PARTICLE_TYPE
- ind_wb_idx_o  out  IDX_W  index of this result
- done_o  out  1  high with the POP_SIZE-th result handed off

## Operation
- Energy:
  - E = Σ self[p(r,c)] + 2·Σ pairs.
  - Horizontal pair contribution: interact[p(r,c)][p(r,c+1)].
  - Vertical pair contribution: interact[p(r,c)][p(r+1,c)].
- Periodic mode adds wrap pairs:
  - interact[p(r,COLS-1)][p(r,0)] only when COLS ≥ 3.
  - interact[p(ROWS-1,c)][p(0,c)] only when ROWS ≥ 3.
  - Smaller dimensions get no wrap pairs, so no pair is counted twice.
- Site code ≥ NUM_PARTICLE_TYPE:
  - That site's self term and every pair containing it contribute 0.
  - bad_code_o is set for that result.
- Arithmetic:
  - Unsigned, internal width ≥ ceil_log2(max possible sum)+1.
  - The final sum is saturated to 2^SELF_FIT_LENGTH−1, and sat_o is set when clipping occurs.
- Configuration:
  - cfg_load_i latches the tables and periodic_i.
  - It is honoured only while the pipeline is empty; otherwise it is ignored.
  - in_ready_o is 0 during any cycle with cfg_load_i=1.
  - An individual is never scored with mixed table versions.
- Population counter:
  - Increments on every output handshake.
  - When it reaches POP_SIZE−1, that handshake has done_o=1 and the counter returns to 0.
- ind_idx_i and the flags travel with the data through the pipeline.

## Timing
- Pipeline stages:
  - S1: table lookup of self and pair terms.
  - S2: per-row partial sums.
  - S3: final sum and saturation, held in the output register.
- Latency: accept at edge N → out_valid_o high after edge N+3. Throughput is 1 per cycle.
- Stall:
  - stall = out_valid_o && !out_ready_i.
  - Every stage holds while stalled.
  - in_ready_o = !stall && !cfg_load_i (combinational).
- Outputs are stable while out_valid_o=1 and out_ready_i=0.
- Bubbles propagate as invalid stages; they do not count toward done_o.
- Reset values:
  - All outputs 0.
  - Stage valid bits 0; counter 0.
  - Tables 0; periodic 0.
- Reset mid-operation:
  - In-flight results are discarded.
  - done_o is not asserted.
  - The counter restarts at 0.
- A simultaneous accept and output handshake is legal; there is no lost or duplicated result.

## Structure
- Shared package fitness_pkg holds:
  - Default parameters.
  - The energy-width function.
  - Table unpack functions (MSB-first field order).
  - The site index helper.
- One sub-module, fitness_pair_lut: combinational (code_a, code_b) → interaction term, with bad-code masking. It is instantiated once per pair.
- Pipeline registers, the stall logic, the config latch and the counter live in the top level.

## Test plan
- Tables self={1,2,3}, interact=[[10,4,1],[4,10,5],[1,5,10]], open mode, 4×4 all type 0 → 496 after 3 cycles, sat_o=0.
- Same tables, periodic mode, all type 0 → 656; a checkerboard of types 0/1, open mode → 16·1.5=24 self + 24 pairs·2·4=192 → 216.
- Tables self[2]=15, interact[2][2]=15, SELF_FIT_LENGTH=10, periodic mode, all type 2 → 1023, sat_o=1.
- out_ready_i held low for 5 cycles during a 50-individual stream → no drops or duplicates, indices in order, in_ready_o low while stalled.
- 50 individuals with random stalls → done_o exactly on idx 49; the next result has done_o=0.
- A site with code 3 → its terms are zeroed and bad_code_o=1.
- cfg_load_i while busy → ignored.
- rst_i mid-stream → out_valid_o=0 immediately and the counter resets.
